// File: rtl/alu_op_issue.sv
// ID-stage ALU-control decoder registered as the ALU slice of ID/EX.
// Stall holds the slice, flush inserts a bubble, and illegal encodings are counted.
module alu_op_issue #(
  parameter int INST_W        = 32,
  parameter int OPCODE_LENGTH = 4,
  parameter int CNT_W         = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [INST_W-1:0]        instr,
  input  logic                     stall,
  input  logic                     flush,
  output logic                     out_valid,
  output logic [OPCODE_LENGTH-1:0] Operation,
  output logic                     alu_src_imm,
  output logic                     is_branch,
  output logic                     illegal,
  output logic [CNT_W-1:0]         illegal_cnt
);

  localparam logic [6:0] OPC_R  = 7'b0110011;
  localparam logic [6:0] OPC_I  = 7'b0010011;
  localparam logic [6:0] OPC_LD = 7'b0000011;
  localparam logic [6:0] OPC_ST = 7'b0100011;
  localparam logic [6:0] OPC_BR = 7'b1100011;

  localparam logic [OPCODE_LENGTH-1:0] OP_AND = OPCODE_LENGTH'(4'b0000);
  localparam logic [OPCODE_LENGTH-1:0] OP_OR  = OPCODE_LENGTH'(4'b0001);
  localparam logic [OPCODE_LENGTH-1:0] OP_ADD = OPCODE_LENGTH'(4'b0010);
  localparam logic [OPCODE_LENGTH-1:0] OP_SUB = OPCODE_LENGTH'(4'b0011);
  localparam logic [OPCODE_LENGTH-1:0] OP_XOR = OPCODE_LENGTH'(4'b0100);
  localparam logic [OPCODE_LENGTH-1:0] OP_SLL = OPCODE_LENGTH'(4'b0101);
  localparam logic [OPCODE_LENGTH-1:0] OP_SRL = OPCODE_LENGTH'(4'b0110);
  localparam logic [OPCODE_LENGTH-1:0] OP_SLT = OPCODE_LENGTH'(4'b0111);
  localparam logic [OPCODE_LENGTH-1:0] OP_BEQ = OPCODE_LENGTH'(4'b1000);
  localparam logic [OPCODE_LENGTH-1:0] OP_SRA = OPCODE_LENGTH'(4'b1001);
  localparam logic [OPCODE_LENGTH-1:0] OP_BNE = OPCODE_LENGTH'(4'b1010);
  localparam logic [OPCODE_LENGTH-1:0] OP_BLT = OPCODE_LENGTH'(4'b1011);
  localparam logic [OPCODE_LENGTH-1:0] OP_BGE = OPCODE_LENGTH'(4'b1100);

  typedef struct packed {
    logic [OPCODE_LENGTH-1:0] op;
    logic                     imm;
    logic                     br;
    logic                     ill;
  } ctl_t;

  logic [6:0] w_opc, w_f7;
  logic [2:0] w_f3;
  logic       w_f7z, w_f7a, w_ok;
  logic       w_unused;
  ctl_t       w_raw, w_dec;
  ctl_t       r_ctl;
  logic       r_vld;
  logic [CNT_W-1:0] r_cnt;

  assign w_opc    = instr[6:0];
  assign w_f3     = instr[14:12];
  assign w_f7     = instr[31:25];
  assign w_f7z    = (w_f7 == 7'b0000000);
  assign w_f7a    = (w_f7 == 7'b0100000);
  // Register/immediate fields are not needed here; fold them away.
  assign w_unused = ^instr;

  always_comb begin
    w_raw = '0;
    w_ok  = 1'b0;
    unique case (w_opc)
      OPC_R: begin
        unique case (w_f3)
          3'b000:  begin w_ok = w_f7z | w_f7a; w_raw.op = w_f7a ? OP_SUB : OP_ADD; end
          3'b111:  begin w_ok = w_f7z; w_raw.op = OP_AND; end
          3'b110:  begin w_ok = w_f7z; w_raw.op = OP_OR;  end
          3'b100:  begin w_ok = w_f7z; w_raw.op = OP_XOR; end
          3'b010:  begin w_ok = w_f7z; w_raw.op = OP_SLT; end
          3'b001:  begin w_ok = w_f7z; w_raw.op = OP_SLL; end
          3'b101:  begin w_ok = w_f7z | w_f7a; w_raw.op = w_f7a ? OP_SRA : OP_SRL; end
          default: w_ok = 1'b0;
        endcase
      end
      OPC_I: begin
        w_raw.imm = 1'b1;
        unique case (w_f3)
          3'b000:  begin w_ok = 1'b1; w_raw.op = OP_ADD; end
          3'b111:  begin w_ok = 1'b1; w_raw.op = OP_AND; end
          3'b110:  begin w_ok = 1'b1; w_raw.op = OP_OR;  end
          3'b100:  begin w_ok = 1'b1; w_raw.op = OP_XOR; end
          3'b010:  begin w_ok = 1'b1; w_raw.op = OP_SLT; end
          3'b001:  begin w_ok = w_f7z; w_raw.op = OP_SLL; end
          3'b101:  begin w_ok = w_f7z | w_f7a; w_raw.op = w_f7a ? OP_SRA : OP_SRL; end
          default: w_ok = 1'b0;
        endcase
      end
      OPC_LD: begin
        w_raw.imm = 1'b1;
        w_raw.op  = OP_ADD;
        w_ok      = (w_f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
      end
      OPC_ST: begin
        w_raw.imm = 1'b1;
        w_raw.op  = OP_ADD;
        w_ok      = (w_f3 inside {3'b000, 3'b001, 3'b010});
      end
      OPC_BR: begin
        w_raw.br = 1'b1;
        unique case (w_f3)
          3'b000:  begin w_ok = 1'b1; w_raw.op = OP_BEQ; end
          3'b001:  begin w_ok = 1'b1; w_raw.op = OP_BNE; end
          3'b100:  begin w_ok = 1'b1; w_raw.op = OP_BLT; end
          3'b101:  begin w_ok = 1'b1; w_raw.op = OP_BGE; end
          default: w_ok = 1'b0;
        endcase
      end
      default: w_ok = 1'b0;
    endcase
  end

  // Illegal decodes collapse to a clean all-zero control with only the flag set.
  always_comb begin
    w_dec = w_raw;
    if (!w_ok) begin
      w_dec     = '0;
      w_dec.ill = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_vld <= 1'b0;
      r_ctl <= '0;
      r_cnt <= '0;
    end else if (flush) begin
      r_vld <= 1'b0;
      r_ctl <= '0;
    end else if (!stall) begin
      r_vld <= in_valid;
      r_ctl <= in_valid ? w_dec : '0;
      if (in_valid && w_dec.ill && (r_cnt != {CNT_W{1'b1}}))
        r_cnt <= r_cnt + 1'b1;
    end
  end

  assign out_valid   = r_vld;
  assign Operation   = r_ctl.op;
  assign alu_src_imm = r_ctl.imm;
  assign is_branch   = r_ctl.br;
  assign illegal     = r_ctl.ill;
  assign illegal_cnt = r_cnt;

endmodule

// File: tb/tb_alu_op_issue.sv
// Scoreboard bench for alu_op_issue: a reference model pushes the expected
// ID/EX slice per edge, each scenario task pops and compares after the edge.
module tb_alu_op_issue;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [31:0] instr;
  logic        stall;
  logic        flush;
  logic        out_valid;
  logic [3:0]  Operation;
  logic        alu_src_imm;
  logic        is_branch;
  logic        illegal;
  logic [7:0]  illegal_cnt;

  alu_op_issue #(.INST_W(32), .OPCODE_LENGTH(4), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .instr(instr),
    .stall(stall), .flush(flush), .out_valid(out_valid), .Operation(Operation),
    .alu_src_imm(alu_src_imm), .is_branch(is_branch), .illegal(illegal),
    .illegal_cnt(illegal_cnt)
  );

  always #5 clk = ~clk;

  // {valid, op[3:0], imm, br, ill, cnt[7:0]}
  logic [15:0] w_act;
  assign w_act = {out_valid, Operation, alu_src_imm, is_branch, illegal, illegal_cnt};

  logic [15:0] sb[$];
  logic [15:0] e;
  int n_vec = 0;
  int n_err = 0;

  logic       m_v, m_imm, m_br, m_ill;
  logic [3:0] m_op;
  logic [7:0] m_cnt;

  // Reference decode: {op, imm, br, ill}
  function automatic logic [6:0] ref_dec(input logic [31:0] x);
    logic [6:0] opc, f7;
    logic [2:0] f3;
    opc = x[6:0]; f3 = x[14:12]; f7 = x[31:25];
    if (opc == 7'h33) begin
      if (f7 == 7'h00) begin
        if (f3 == 3'd0) return {4'h2, 3'b000};
        if (f3 == 3'd1) return {4'h5, 3'b000};
        if (f3 == 3'd2) return {4'h7, 3'b000};
        if (f3 == 3'd4) return {4'h4, 3'b000};
        if (f3 == 3'd5) return {4'h6, 3'b000};
        if (f3 == 3'd6) return {4'h1, 3'b000};
        if (f3 == 3'd7) return {4'h0, 3'b000};
      end else if (f7 == 7'h20) begin
        if (f3 == 3'd0) return {4'h3, 3'b000};
        if (f3 == 3'd5) return {4'h9, 3'b000};
      end
    end else if (opc == 7'h13) begin
      if (f3 == 3'd0) return {4'h2, 3'b100};
      if (f3 == 3'd7) return {4'h0, 3'b100};
      if (f3 == 3'd6) return {4'h1, 3'b100};
      if (f3 == 3'd4) return {4'h4, 3'b100};
      if (f3 == 3'd2) return {4'h7, 3'b100};
      if (f3 == 3'd1 && f7 == 7'h00) return {4'h5, 3'b100};
      if (f3 == 3'd5 && f7 == 7'h00) return {4'h6, 3'b100};
      if (f3 == 3'd5 && f7 == 7'h20) return {4'h9, 3'b100};
    end else if (opc == 7'h03) begin
      if (f3 != 3'd3 && f3 != 3'd6 && f3 != 3'd7) return {4'h2, 3'b100};
    end else if (opc == 7'h23) begin
      if (f3 <= 3'd2) return {4'h2, 3'b100};
    end else if (opc == 7'h63) begin
      if (f3 == 3'd0) return {4'h8, 3'b010};
      if (f3 == 3'd1) return {4'hA, 3'b010};
      if (f3 == 3'd4) return {4'hB, 3'b010};
      if (f3 == 3'd5) return {4'hC, 3'b010};
    end
    return {4'h0, 3'b001};
  endfunction

  task automatic model_reset();
    m_v = 0; m_op = 0; m_imm = 0; m_br = 0; m_ill = 0; m_cnt = 0;
    sb.delete();
  endtask

  // Drive one cycle; the model predicts the post-edge state and pushes it.
  task automatic step(input logic v, input logic [31:0] ins, input logic st, input logic fl);
    logic [6:0] d;
    in_valid = v; instr = ins; stall = st; flush = fl;
    d = ref_dec(ins);
    if (fl) begin
      m_v = 0; m_op = 0; m_imm = 0; m_br = 0; m_ill = 0;
    end else if (!st) begin
      m_v = v;
      {m_op, m_imm, m_br, m_ill} = v ? d : 7'd0;
      if (v && d[0] && m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
    end
    sb.push_back({m_v, m_op, m_imm, m_br, m_ill, m_cnt});
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1; in_valid = 1; instr = 32'h40B50533; stall = 0; flush = 0;
    model_reset();
    #2;
    n_vec++;
    if (w_act !== 16'h0000) begin n_err++; $display("FAIL reset_state: got %h exp %h", w_act, 16'h0000); end
    @(posedge clk); #1;
    n_vec++;
    if (w_act !== 16'h0000) begin n_err++; $display("FAIL reset_hold: got %h exp %h", w_act, 16'h0000); end
    @(negedge clk);
    reset = 0;
  endtask

  task automatic test_sub();
    step(1, 32'h40B50533, 0, 0);
    e = sb.pop_front(); n_vec++;
    if (w_act !== e) begin n_err++; $display("FAIL sub_sb: got %h exp %h", w_act, e); end
    n_vec++;
    if ({out_valid, Operation, alu_src_imm, is_branch} !== 7'b1_0011_0_0) begin
      n_err++; $display("FAIL sub_const: got %b exp 1001100", {out_valid, Operation, alu_src_imm, is_branch});
    end
  endtask

  task automatic test_shift_imm();
    logic [31:0] ins [2] = '{32'h4025D593, 32'h0025D593};
    logic [3:0]  ops [2] = '{4'b1001, 4'b0110};
    for (int i = 0; i < 2; i++) begin
      step(1, ins[i], 0, 0);
      e = sb.pop_front(); n_vec++;
      if (w_act !== e) begin n_err++; $display("FAIL shift_sb%0d: got %h exp %h", i, w_act, e); end
      n_vec++;
      if ({Operation, alu_src_imm} !== {ops[i], 1'b1}) begin
        n_err++; $display("FAIL shift_const%0d: got %b exp %b", i, {Operation, alu_src_imm}, {ops[i], 1'b1});
      end
    end
  endtask

  task automatic test_branch();
    logic [31:0] ins [3] = '{32'h00B50463, 32'h00B54463, 32'h00B52463};
    logic [6:0]  ex  [3] = '{7'b1000_1_0_0, 7'b1011_1_0_0, 7'b0000_0_0_1};
    for (int i = 0; i < 3; i++) begin
      step(1, ins[i], 0, 0);
      e = sb.pop_front(); n_vec++;
      if (w_act !== e) begin n_err++; $display("FAIL branch_sb%0d: got %h exp %h", i, w_act, e); end
      n_vec++;
      if ({Operation, is_branch, alu_src_imm, illegal} !== ex[i]) begin
        n_err++; $display("FAIL branch_const%0d: got %b exp %b", i, {Operation, is_branch, alu_src_imm, illegal}, ex[i]);
      end
    end
    n_vec++;
    if (illegal_cnt !== 8'd1) begin n_err++; $display("FAIL branch_cnt: got %0d exp 1", illegal_cnt); end
  endtask

  task automatic test_stall();
    step(1, 32'h0005A503, 0, 0);
    e = sb.pop_front(); n_vec++;
    if (w_act !== e) begin n_err++; $display("FAIL lw_sb: got %h exp %h", w_act, e); end
    for (int i = 0; i < 3; i++) begin
      step(1, 32'h00B50533, 1, 0);
      e = sb.pop_front(); n_vec++;
      if (w_act !== e) begin n_err++; $display("FAIL stall_sb%0d: got %h exp %h", i, w_act, e); end
      n_vec++;
      if ({out_valid, Operation, alu_src_imm} !== 6'b1_0010_1) begin
        n_err++; $display("FAIL stall_hold%0d: got %b exp 100101", i, {out_valid, Operation, alu_src_imm});
      end
    end
    step(1, 32'h00B50533, 0, 0);
    e = sb.pop_front(); n_vec++;
    if (w_act !== e) begin n_err++; $display("FAIL stall_release: got %h exp %h", w_act, e); end
    n_vec++;
    if ({Operation, alu_src_imm} !== 5'b0010_0) begin
      n_err++; $display("FAIL stall_add: got %b exp 00100", {Operation, alu_src_imm});
    end
  endtask

  task automatic test_invalid();
    step(0, 32'h40B50533, 0, 0);
    e = sb.pop_front(); n_vec++;
    if (w_act !== e) begin n_err++; $display("FAIL invalid_sb: got %h exp %h", w_act, e); end
    n_vec++;
    if (w_act[15:8] !== 8'h00) begin n_err++; $display("FAIL invalid_zero: got %h exp 00", w_act[15:8]); end
  endtask

  task automatic test_flush_stall();
    logic [7:0] c0;
    step(1, 32'h0000007F, 0, 0);
    e = sb.pop_front(); n_vec++;
    if (w_act !== e) begin n_err++; $display("FAIL preflush_sb: got %h exp %h", w_act, e); end
    c0 = illegal_cnt;
    step(1, 32'h0000007F, 1, 1);
    e = sb.pop_front(); n_vec++;
    if (w_act !== e) begin n_err++; $display("FAIL flush_sb: got %h exp %h", w_act, e); end
    n_vec++;
    if (w_act !== {8'h00, c0}) begin n_err++; $display("FAIL flush_const: got %h exp %h", w_act, {8'h00, c0}); end
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 260; i++) begin
      step(1, 32'h0000007F, 0, 0);
      e = sb.pop_front(); n_vec++;
      if (w_act !== e) begin n_err++; $display("FAIL sat_sb%0d: got %h exp %h", i, w_act, e); end
    end
    n_vec++;
    if (illegal_cnt !== 8'd255) begin n_err++; $display("FAIL sat_cnt: got %0d exp 255", illegal_cnt); end
    // Reset lands between edges; outputs must clear before the next edge.
    #2 reset = 1;
    model_reset();
    #1;
    n_vec++;
    if (w_act !== 16'h0000) begin n_err++; $display("FAIL async_reset: got %h exp %h", w_act, 16'h0000); end
    @(posedge clk); #1;
    reset = 0;
    step(1, 32'h00B55463, 0, 0);
    e = sb.pop_front(); n_vec++;
    if (w_act !== e) begin n_err++; $display("FAIL post_reset_sb: got %h exp %h", w_act, e); end
    n_vec++;
    if (w_act !== {1'b1, 4'hC, 3'b010, 8'd0}) begin
      n_err++; $display("FAIL post_reset_bge: got %h exp %h", w_act, {1'b1, 4'hC, 3'b010, 8'd0});
    end
  endtask

  task automatic test_random();
    logic [31:0] pool [22] = '{
      32'h00B53533, 32'h40B57533, 32'h0205D593, 32'h0025B593, 32'h0005B503,
      32'h0005A023, 32'h0005B023, 32'h00B55463, 32'h00B51463, 32'h00000013,
      32'h0000007F, 32'h00B51533, 32'h00B54533, 32'h00B56533, 32'h00B52533,
      32'h0025C593, 32'h40259593, 32'hFFF5E593, 32'h0005C503, 32'h0005D503,
      32'h0005E503, 32'h40B55533};
    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 7) != 0), pool[$urandom_range(0, 21)],
           ($urandom_range(0, 5) == 0), ($urandom_range(0, 9) == 0));
      e = sb.pop_front(); n_vec++;
      if (w_act !== e) begin n_err++; $display("FAIL rand_sb%0d: got %h exp %h", i, w_act, e); end
    end
  endtask

  initial begin
    test_reset();
    test_sub();
    test_shift_imm();
    test_branch();
    test_stall();
    test_invalid();
    test_flush_stall();
    test_saturate();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alu_op_issue.md
Name: alu_op_issue

Overview:
- Produces the 4-bit Operation code and operand-select controls consumed by the pipeline ALU.
- Decodes the fetched instruction word in ID and registers the result as the ALU-control slice of the ID/EX pipeline register.
- Supports pipeline stall and flush and flags illegal encodings.
- Keeps a saturating illegal-instruction counter for debug.

Parameters:
- INST_W, 32, instruction word width.
- OPCODE_LENGTH, 4, width of the Operation code driven to the ALU.
- CNT_W, 8, width of the illegal-instruction counter.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  instr holds a real instruction this cycle.
- instr  input  INST_W  instruction word from IF/ID.
- stall  input  1  hold the ID/EX slice; input is not consumed.
- flush  input  1  insert a bubble into EX.
- out_valid  output  1  EX-stage control is valid.
- Operation  output  OPCODE_LENGTH  ALU operation code.
- alu_src_imm  output  1  1 = SrcB from immediate, 0 = from rs2.
- is_branch  output  1  EX instruction is a conditional branch.
- illegal  output  1  EX instruction was an undecodable encoding.
- illegal_cnt  output  CNT_W  saturating count of illegal instructions issued.

Behaviour:
- Field slices: opcode=instr[6:0], funct3=instr[14:12], funct7=instr[31:25].
- Operation encodings: AND 0000, OR 0001, ADD 0010, SUB 0011, XOR 0100, SLL 0101, SRL 0110, SLT 0111, BEQ 1000, SRA 1001, BNE 1010, BLT 1011, BGE 1100.
- R-type, opcode 0110011, alu_src_imm=0:
  - f3 000: f7 0000000 → ADD, 0100000 → SUB.
  - f3 111 → AND; 110 → OR; 100 → XOR; 010 → SLT (each requires f7=0).
  - f3 001, f7=0 → SLL.
  - f3 101: f7=0 → SRL, f7=0100000 → SRA.
  - Anything else is illegal.
- I-ALU, opcode 0010011, alu_src_imm=1:
  - f3 000 ADD, 111 AND, 110 OR, 100 XOR, 010 SLT (funct7 ignored).
  - f3 001 SLL requires f7=0.
  - f3 101: f7=0 → SRL, f7=0100000 → SRA.
  - f3 011 and any bad funct7 are illegal.
- Load, opcode 0000011: f3 in {000,001,010,100,101} → ADD, alu_src_imm=1. Other f3 is illegal.
- Store, opcode 0100011: f3 in {000,001,010} → ADD, alu_src_imm=1. Other f3 is illegal.
- Branch, opcode 1100011, alu_src_imm=0, is_branch=1:
  - f3 000 BEQ, 001 BNE, 100 BLT, 101 BGE.
  - Other f3 is illegal.
- All other opcodes are illegal.
- Illegal decode drives Operation=0000, alu_src_imm=0, is_branch=0, illegal=1.
- Latency: registered, one cycle. Input sampled at edge N appears on outputs after edge N.
- Per-edge priority:
  - reset: everything 0, asynchronously.
  - else flush: out_valid=0, Operation=0, alu_src_imm=0, is_branch=0, illegal=0. Counter unchanged.
  - else stall: every output holds its value. Counter unchanged.
  - else load: out_valid<=in_valid.
    - If in_valid=1, load decoded fields.
    - If in_valid=0, load all fields as 0.
- illegal_cnt increments by 1 only on a load edge with in_valid=1 and an illegal decode. It saturates at 2^CNT_W-1 and never wraps.
- flush+stall together behave as flush.
- A reset asserted mid-stall clears all outputs immediately. The first edge after reset deasserts is a normal load.
- Outputs are a pure function of registered state, with no combinational path from inputs.
- When out_valid=0, consumers ignore Operation, alu_src_imm, is_branch and illegal; all four are 0 in that state.

Test Plan:
- Reset, then apply instr=0x40B50533 (sub a0,a0,a1) with in_valid=1 → the next cycle shows out_valid=1, Operation=0011, alu_src_imm=0, is_branch=0.
- Issue 0x4025D593 (srai a1,a1,2), then 0x0025D593 (srli) on consecutive cycles → Operation=1001 then 0110, alu_src_imm=1 both cycles, with 1-cycle latency each.
- Issue branch 0x00B50463 (beq), then 0x00B54463 (blt), then f3=010 branch 0x00B52463 → Operation 1000, 1011, then illegal=1, Operation=0000, illegal_cnt=1.
- Load lw 0x0005A503, then assert stall for 3 cycles while instr changes to 0x00B50533 → outputs hold Operation=0010, alu_src_imm=1 during the stall. The add then appears one cycle after stall drops.
- Assert stall and flush together with in_valid=1 → out_valid=0, all fields 0, illegal_cnt unchanged.
- Drive opcode 0x7F with in_valid=1 for 260 cycles → illegal_cnt saturates at 255. Reset asserted mid-run clears it to 0 asynchronously, before the next clock edge.
